// File: rtl/nms_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : nms_stream
//  Purpose  : Streaming, frame-aware non-maximum suppression for the Canny
//             pipeline. Raster-ordered {magnitude, direction} pixels arrive
//             one per handshake. The 3x3 neighbourhood is rebuilt internally
//             from two line buffers plus a two-column window. One suppressed,
//             saturated edge-strength pixel is emitted per input pixel.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock
//    rst        in   asynchronous active-high reset
//    in_valid   in   input pixel valid
//    in_ready   out  block can accept an input pixel this cycle
//    in_mag     in   [W-1:0]     gradient magnitude
//    in_dir     in   [3:0]       quantised direction, 1..8 legal
//    out_valid  out  output pixel valid
//    out_ready  in   downstream accepts the output
//    out_pix    out  [OUT_W-1:0] suppressed edge strength
//    out_last   out  high with the final pixel of a frame
// ============================================================================
module nms_stream #(
  parameter int W      = 12,
  parameter int OUT_W  = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int STRICT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_mag,
  input  logic [3:0]       in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_pix,
  output logic             out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] C_ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Position of the next pixel entering the window, and of the next centre.
  logic [CW-1:0] r_in_col, r_c_col;
  logic [RW-1:0] r_in_row, r_c_row;

  // Line buffers: r_lb_top holds row r-2, r_lb_mid row r-1 (indexed by column).
  logic [W-1:0] r_lb_top [IMG_W];
  logic [W-1:0] r_lb_mid [IMG_W];
  logic [3:0]   r_lb_dir [IMG_W];

  // Window columns c-2 (r_l) and c-1 (r_m); index 0 = top row, 2 = bottom row.
  logic [W-1:0] r_l [3];
  logic [W-1:0] r_m [3];
  logic [3:0]   r_dir_c;

  logic             r_out_valid, r_out_last;
  logic [OUT_W-1:0] r_out_pix;

  logic             w_slot_free, w_held_last, w_accept, w_flush_step;
  logic             w_advance, w_load;
  logic [W-1:0]     w_new_top, w_new_mid, w_new_bot, w_c, w_a, w_b;
  logic [3:0]       w_new_dir;
  logic             w_dir_ok, w_border, w_survive, w_is_last;
  logic [OUT_W-1:0] w_sat, w_result;

  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_held_last  = r_out_valid && r_out_last;
  assign in_ready     = !rst && ((r_state == FILL) || ((r_state == RUN) && w_slot_free));
  assign w_accept     = in_valid && in_ready;
  // Flush inserts zero pixels, one per free output slot, until the last is loaded.
  assign w_flush_step = (r_state == FLUSH) && w_slot_free && !w_held_last;
  assign w_advance    = w_accept || w_flush_step;
  assign w_load       = ((r_state == RUN) && w_accept) || w_flush_step;

  // Right-hand column of the neighbourhood: read before this cycle's write.
  assign w_new_top = r_lb_top[r_in_col];
  assign w_new_mid = r_lb_mid[r_in_col];
  assign w_new_bot = (r_state == FLUSH) ? '0 : in_mag;
  assign w_new_dir = (r_state == FLUSH) ? 4'd0 : in_dir;
  assign w_c       = r_m[1];

  always_comb begin
    w_a      = '0;
    w_b      = '0;
    w_dir_ok = 1'b1;
    case (r_dir_c)
      4'd1, 4'd8: begin w_a = r_l[1];    w_b = w_new_mid; end  // left / right
      4'd2, 4'd3: begin w_a = r_l[0];    w_b = w_new_bot; end  // top-left / bottom-right
      4'd4, 4'd5: begin w_a = r_m[0];    w_b = r_m[2];    end  // top / bottom
      4'd6, 4'd7: begin w_a = w_new_top; w_b = r_l[2];    end  // top-right / bottom-left
      default:    w_dir_ok = 1'b0;
    endcase
  end

  assign w_survive = (STRICT != 0) ? ((w_c >  w_a) && (w_c >  w_b))
                                   : ((w_c >= w_a) && (w_c >= w_b));

  generate
    if (OUT_W >= W) begin : g_no_sat
      assign w_sat = OUT_W'(w_c);
    end else begin : g_sat
      localparam logic [W-1:0] C_SAT_MAX = W'((1 << OUT_W) - 1);
      assign w_sat = (w_c > C_SAT_MAX) ? '1 : w_c[OUT_W-1:0];
    end
  endgenerate

  // Border masking also hides window data wrapped from the previous row and
  // stale line-buffer contents at the top of a frame.
  assign w_border  = (r_c_row == '0) || (r_c_row == C_ROW_LAST) ||
                     (r_c_col == '0) || (r_c_col == C_COL_LAST);
  assign w_result  = (w_border || !w_dir_ok || !w_survive) ? '0 : w_sat;
  assign w_is_last = (r_c_row == C_ROW_LAST) && (r_c_col == C_COL_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:  if (w_accept && (r_in_row == C_ROW_ONE) && (r_in_col == '0))
               w_state_nxt = RUN;
      RUN:   if (w_accept && (r_in_row == C_ROW_LAST) && (r_in_col == C_COL_LAST))
               w_state_nxt = FLUSH;
      FLUSH: if (w_held_last && out_ready)
               w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_c_col     <= '0;
      r_c_row     <= '0;
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == FLUSH) && (w_state_nxt == FILL)) begin
        r_in_col <= '0;
        r_in_row <= '0;
        r_c_col  <= '0;
        r_c_row  <= '0;
      end else begin
        if (w_advance) begin
          if (r_in_col == C_COL_LAST) begin
            r_in_col <= '0;
            r_in_row <= (r_in_row == C_ROW_LAST) ? '0 : r_in_row + 1'b1;
          end else begin
            r_in_col <= r_in_col + 1'b1;
          end
        end
        if (w_load) begin
          if (r_c_col == C_COL_LAST) begin
            r_c_col <= '0;
            r_c_row <= (r_c_row == C_ROW_LAST) ? '0 : r_c_row + 1'b1;
          end else begin
            r_c_col <= r_c_col + 1'b1;
          end
        end
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pix   <= w_result;
        r_out_last  <= w_is_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Data path storage carries no reset; the border rule masks stale content.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_lb_top[r_in_col] <= w_new_mid;
      r_lb_mid[r_in_col] <= w_new_bot;
      r_lb_dir[r_in_col] <= w_new_dir;
      r_l[0]  <= r_m[0];
      r_l[1]  <= r_m[1];
      r_l[2]  <= r_m[2];
      r_m[0]  <= w_new_top;
      r_m[1]  <= w_new_mid;
      r_m[2]  <= w_new_bot;
      r_dir_c <= r_lb_dir[r_in_col];
    end
  end

  assign out_valid = r_out_valid;
  assign out_pix   = r_out_pix;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_nms_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_nms_stream
//  Purpose  : Self-checking bench for nms_stream on a 4x3 image. Two
//             instances (STRICT=0 and STRICT=1) see identical stimulus; each
//             has its own expected-output queue filled from a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nms_stream;

  localparam int W = 12, OUT_W = 8, IW = 4, IH = 3, NPIX = IW * IH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [W-1:0] in_mag = '0;
  logic [3:0] in_dir = '0;
  logic out_ready = 1'b1;
  logic in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic [OUT_W-1:0] out_pix0, out_pix1;

  always #5 clk = ~clk;

  nms_stream #(.W(W), .OUT_W(OUT_W), .IMG_W(IW), .IMG_H(IH), .STRICT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_mag(in_mag), .in_dir(in_dir), .out_valid(out_valid0),
    .out_ready(out_ready), .out_pix(out_pix0), .out_last(out_last0));

  nms_stream #(.W(W), .OUT_W(OUT_W), .IMG_W(IW), .IMG_H(IH), .STRICT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_mag(in_mag), .in_dir(in_dir), .out_valid(out_valid1),
    .out_ready(out_ready), .out_pix(out_pix1), .out_last(out_last1));

  typedef struct { logic [7:0] pix; logic last; logic flush; } exp_t;
  typedef struct { int cmag; int cdir; int n_idx; int n_mag; int n2_idx; int n2_mag;
                   int bg; int exp0; int exp1; } vec_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int fm[NPIX], fd[NPIX];
  logic [7:0] cap0[NPIX], cap1[NPIX];
  int out_pos0 = 0, out_pos1 = 0, n_last0 = 0, n_last1 = 0, frames_done = 0;
  int n_cmp = 0, n_fail = 0;
  bit rand_ready = 0;
  bit ps0 = 0, ps1 = 0, pl0 = 0, pl1 = 0;
  logic [7:0] pp0 = '0, pp1 = '0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic int px(input int r, input int c);
    return fm[r*IW + c];
  endfunction

  // Reference: expressed in image coordinates, independent of any windowing.
  function automatic int model_pix(input int r, input int c, input bit strict);
    int a, b, cm;
    if (r == 0 || r == IH-1 || c == 0 || c == IW-1) return 0;
    cm = px(r, c);
    case (fd[r*IW + c])
      1, 8: begin a = px(r, c-1);   b = px(r, c+1);   end
      2, 3: begin a = px(r-1, c-1); b = px(r+1, c+1); end
      4, 5: begin a = px(r-1, c);   b = px(r+1, c);   end
      6, 7: begin a = px(r-1, c+1); b = px(r+1, c-1); end
      default: return 0;
    endcase
    if (strict ? (cm > a && cm > b) : (cm >= a && cm >= b))
      return (cm > 255) ? 255 : cm;
    return 0;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < NPIX; i++) begin
      e.last  = (i == NPIX-1);
      e.flush = (i >= NPIX - (IW+1));
      e.pix   = 8'(model_pix(i / IW, i % IW, 1'b0));
      q0.push_back(e);
      e.pix   = 8'(model_pix(i / IW, i % IW, 1'b1));
      q1.push_back(e);
    end
  endtask

  task automatic drive_pixel(input int m, input int d);
    bit done;
    int n;
    done = 0;
    n = 0;
    in_valid = 1'b1;
    in_mag = W'(m);
    in_dir = 4'(d);
    while (!done) begin
      @(negedge clk);
      if (in_ready0) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        n++;
        if (n > 200) begin
          timeout_fail("accept_timeout");
          done = 1;
        end
      end
    end
  endtask

  task automatic drive_frame(input int upto);
    for (int i = 0; i < upto; i++) drive_pixel(fm[i], fd[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) timeout_fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      ps0 = 0; ps1 = 0; out_pos0 = 0; out_pos1 = 0;
    end else begin
      if (ps0) begin
        check("hold_valid0", out_valid0, 1);
        check("hold_pix0", out_pix0, pp0);
        check("hold_last0", out_last0, pl0);
      end
      if (ps1) begin
        check("hold_valid1", out_valid1, 1);
        check("hold_pix1", out_pix1, pp1);
        check("hold_last1", out_last1, pl1);
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) timeout_fail("unexpected_out0");
        else begin
          e0 = q0.pop_front();
          check($sformatf("pix0[%0d]", out_pos0), out_pix0, e0.pix);
          check($sformatf("last0[%0d]", out_pos0), out_last0, e0.last);
          if (e0.flush) check("flush_in_ready0", in_ready0, 0);
          cap0[out_pos0] = out_pix0;
          out_pos0 = (out_pos0 + 1) % NPIX;
          if (out_last0) n_last0++;
        end
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) timeout_fail("unexpected_out1");
        else begin
          e1 = q1.pop_front();
          check($sformatf("pix1[%0d]", out_pos1), out_pix1, e1.pix);
          check($sformatf("last1[%0d]", out_pos1), out_last1, e1.last);
          cap1[out_pos1] = out_pix1;
          out_pos1 = (out_pos1 + 1) % NPIX;
          if (out_last1) n_last1++;
        end
      end
      ps0 = out_valid0 && !out_ready; pp0 = out_pix0; pl0 = out_last0;
      ps1 = out_valid1 && !out_ready; pp1 = out_pix1; pl1 = out_last1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tab[11];

  initial begin
    // index 5 is centre (1,1); 0=TL 1=T 2=TR 4=L 6=R 8=BL 9=B 10=BR
    tab[0]  = '{100, 1, -1, 0, -1, 0, 100, 100, 0};
    tab[1]  = '{300, 1,  4, 200, 6, 200, 0, 255, 255};
    tab[2]  = '{300, 1,  4, 300, 6, 200, 0, 255, 0};
    tab[3]  = '{ 50, 2,  0, 60, -1, 0, 0, 0, 0};
    tab[4]  = '{ 50, 2,  1, 60, -1, 0, 0, 50, 50};
    tab[5]  = '{ 50, 4,  1, 60, -1, 0, 0, 0, 0};
    tab[6]  = '{ 50, 4,  4, 60, -1, 0, 0, 50, 50};
    tab[7]  = '{ 50, 6,  2, 60, -1, 0, 0, 0, 0};
    tab[8]  = '{ 50, 6,  0, 60, -1, 0, 0, 50, 50};
    tab[9]  = '{4095, 0, -1, 0, -1, 0, 0, 0, 0};
    tab[10] = '{4095, 12, -1, 0, -1, 0, 0, 0, 0};

    #12;
    check("rst_in_ready", in_ready0, 0);
    check("rst_out_valid0", out_valid0, 0);
    check("rst_out_valid1", out_valid1, 0);
    check("rst_out_pix", out_pix0, 0);
    check("rst_out_last", out_last0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 11; t++) begin
      for (int i = 0; i < NPIX; i++) begin
        fm[i] = tab[t].bg;
        fd[i] = tab[t].cdir;
      end
      fm[5] = tab[t].cmag;
      if (tab[t].n_idx >= 0)  fm[tab[t].n_idx]  = tab[t].n_mag;
      if (tab[t].n2_idx >= 0) fm[tab[t].n2_idx] = tab[t].n2_mag;
      push_frame();
      drive_frame(NPIX);
      wait_drain();
      check($sformatf("vec%0d_centre_s0", t), cap0[5], tab[t].exp0);
      check($sformatf("vec%0d_centre_s1", t), cap1[5], tab[t].exp1);
      if (t == 0) check("vec0_pix12_s0", cap0[6], 100);
      frames_done++;
    end

    // Three back-to-back random frames with a randomly stalling sink.
    rand_ready = 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        fm[i] = (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                               : int'($urandom_range(0, 400)));
        fd[i] = int'($urandom_range(0, 15));
      end
      push_frame();
      drive_frame(NPIX);
    end
    wait_drain();
    frames_done += 3;
    rand_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    // Abort a frame in RUN after seven accepted pixels.
    for (int i = 0; i < NPIX; i++) begin
      fm[i] = (i * 37) % 500;
      fd[i] = (i % 8) + 1;
    end
    push_frame();
    drive_frame(7);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid0", out_valid0, 0);
    check("midrst_out_valid1", out_valid1, 0);
    check("midrst_in_ready", in_ready0, 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NPIX; i++) begin
      fm[i] = (i * 53 + 20) % 400;
      fd[i] = ((i * 3) % 8) + 1;
    end
    push_frame();
    drive_frame(NPIX);
    wait_drain();
    frames_done++;

    check("last_pulses0", n_last0, frames_done);
    check("last_pulses1", n_last1, frames_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
